pipe_chain: RTL and testbench
=============================

PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of pipeline register stages, legal range 2..8.
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning the payload width per stage.
REQ-003 The module SHALL have parameter ADDR_W, default 5, meaning the destination-register tag width.
REQ-004 The module SHALL have parameter NUM_SRC, default 2, meaning the number of forwarding query ports, legal range 1..4.
REQ-005 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit, a synchronous, active-high reset.
REQ-007 The module SHALL have port in_valid, input, 1 bit, meaning an instruction is presented to stage 0.
REQ-008 The module SHALL have port in_data, input, DATA_W bits, the payload.
REQ-009 The module SHALL have port in_dst, input, ADDR_W bits, the destination register tag.
REQ-010 The module SHALL have port in_wen, input, 1 bit, the register-write intent.
REQ-011 The module SHALL have port in_ready, output, 1 bit, meaning stage 0 accepts this cycle.
REQ-012 The module SHALL have port stall, input, DEPTH bits, the per-stage hold request (bit k = stage k).
REQ-013 The module SHALL have port flush, input, DEPTH bits, the per-stage kill request.
REQ-014 The module SHALL have port src_addr, input, NUM_SRC*ADDR_W bits, the forwarding query tags.
REQ-015 The module SHALL have port fwd_hit, output, NUM_SRC bits, meaning a match was found per query.
REQ-016 The module SHALL have port fwd_stage, output, NUM_SRC*3 bits, the index of the matching stage.
REQ-017 The module SHALL have port fwd_data, output, NUM_SRC*DATA_W bits, the forwarded payload.
REQ-018 The module SHALL have outputs out_valid, out_data, out_dst and out_wen, which are the contents of stage DEPTH-1.
REQ-019 The module SHALL have port stage_valid, output, DEPTH bits, the valid bit of each stage.

Function
REQ-020 hold[k] SHALL equal the OR of stall[j] for all j>=k; a stall SHALL therefore freeze that stage and every older-input stage.
REQ-021 The per-stage update priority SHALL be: flush[k] -> valid=0, wen=0; else hold[k] -> retain; else if k>0 and hold[k-1] -> bubble (valid=0, wen=0); else load from stage k-1, or from the input when k=0.
REQ-022 Flush SHALL win over stall in the same stage and cycle.
REQ-023 in_ready SHALL equal !hold[0] combinationally; input SHALL be captured only when in_valid && in_ready, and otherwise a bubble SHALL be loaded if !hold[0].
REQ-024 The latency with no stalls SHALL be DEPTH cycles from capture to out_valid=1, with a throughput of 1 per cycle.
REQ-025 A bubble stage SHALL carry wen=0 and SHALL never produce a forwarding hit; its data and dst contents are don't-care.
REQ-026 For each query i: if src_addr[i]==0, fwd_hit[i] SHALL be 0; otherwise the module SHALL select the lowest k (youngest) with stage_valid[k] && wen[k] && dst[k]==src_addr[i].
REQ-027 On a hit, fwd_hit=1 and fwd_stage=k SHALL hold and fwd_data SHALL equal data[k].
REQ-028 On a miss, fwd_hit=0, fwd_stage=0 and fwd_data=0 SHALL hold.
REQ-029 Forwarding outputs SHALL be purely combinational from stage registers and src_addr, with no input-to-output path from in_*.
REQ-030 A stage that is both held and flushed SHALL be killed, and stages behind it SHALL still hold.

Reset
REQ-031 While rst=1 at a clock edge, all stage valid, wen, dst and data SHALL clear to 0.
REQ-032 On the cycle after reset, out_valid=0, stage_valid=0 and fwd_hit=0 SHALL hold.
REQ-033 Reset SHALL override stall and flush, including when asserted mid-stream.
REQ-034 in_ready SHALL follow stall only, and is not gated by rst.

Structure
REQ-035 The shared defines file SHALL hold the default width constants (payload width 32, register tag width 5) and the stage-index width 3.
REQ-036 One sub-module, pipe_stage_reg, SHALL implement a single stage with hold, bubble and flush, and SHALL be instantiated DEPTH times by generate.
REQ-037 Forwarding selection SHALL be a priority loop inside pipe_chain, not a separate module.

Verification
REQ-038 Reset then stream: in_data=0x11,0x22,0x33 on consecutive cycles with no stall -> out_data 0x11,0x22,0x33 appear on cycles 4, 5 and 6 after the first capture, with out_valid=1 on each.
REQ-039 Stall: stall[1]=1 for 2 cycles with stages 0..1 full -> stages 0..1 frozen, in_ready=0, stage 2 receives 2 bubbles, and there is no data loss or duplication after release.
REQ-040 Flush and stall together: flush[1]=1 and stall[1]=1 -> stage 1 valid=0 next cycle, stage 0 retains its contents.
REQ-041 Forwarding priority: stage 0 dst=3 data=0xAA, stage 2 dst=3 data=0xBB, src_addr=3 -> fwd_hit=1, fwd_stage=0, fwd_data=0xAA.
REQ-042 Forwarding exclusions: src_addr=0 with a stage dst=0 wen=1, or a matching stage with wen=0 -> fwd_hit=0, fwd_data=0.
REQ-043 Mid-stream reset: rst=1 for one cycle with 3 stages valid -> all valid clear next cycle, and a fresh stream then emerges after DEPTH cycles.

Source files
------------

// File: rtl/pipe_chain_pkg.sv
// Shared widths and stage-update encoding for the pipe_chain pipeline.
`default_nettype none

package pipe_chain_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int STAGE_IDX_W = 3;

  typedef enum logic [1:0] {
    STAGE_LOAD   = 2'd0,
    STAGE_HOLD   = 2'd1,
    STAGE_BUBBLE = 2'd2,
    STAGE_KILL   = 2'd3
  } stage_op_e;

  // Kill beats hold, hold beats bubble, bubble beats load.
  function automatic stage_op_e stage_op(input logic flush, input logic hold, input logic bubble);
    stage_op_e op;
    if (flush)       op = STAGE_KILL;
    else if (hold)   op = STAGE_HOLD;
    else if (bubble) op = STAGE_BUBBLE;
    else             op = STAGE_LOAD;
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_chain_stage_reg.sv
// One pipeline stage register with synchronous reset, flush, hold and bubble insertion.
`default_nettype none

module pipe_stage_reg
  import pipe_chain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              bubble,
  input  logic              prev_valid,
  input  logic              prev_wen,
  input  logic [ADDR_W-1:0] prev_dst,
  input  logic [DATA_W-1:0] prev_data,
  output logic              valid,
  output logic              wen,
  output logic [ADDR_W-1:0] dst,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      wen   <= 1'b0;
      dst   <= '0;
      data  <= '0;
    end else begin
      case (stage_op(flush, hold, bubble))
        STAGE_KILL, STAGE_BUBBLE: begin
          // Payload is left as is; a stage with valid=0 and wen=0 is never observed.
          valid <= 1'b0;
          wen   <= 1'b0;
        end
        STAGE_HOLD: begin
          valid <= valid;
          wen   <= wen;
        end
        default: begin
          valid <= prev_valid;
          wen   <= prev_wen;
          dst   <= prev_dst;
          data  <= prev_data;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_chain.sv
// Multi-stage instruction pipeline with per-stage stall/flush and youngest-first result forwarding.
`default_nettype none

module pipe_chain
  import pipe_chain_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_SRC = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [ADDR_W-1:0]             in_dst,
  input  logic                          in_wen,
  output logic                          in_ready,
  input  logic [DEPTH-1:0]              stall,
  input  logic [DEPTH-1:0]              flush,
  input  logic [NUM_SRC*ADDR_W-1:0]     src_addr,
  output logic [NUM_SRC-1:0]            fwd_hit,
  output logic [NUM_SRC*STAGE_IDX_W-1:0] fwd_stage,
  output logic [NUM_SRC*DATA_W-1:0]     fwd_data,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [ADDR_W-1:0]             out_dst,
  output logic                          out_wen,
  output logic [DEPTH-1:0]              stage_valid
);

  logic [DEPTH-1:0]  hold;
  logic [DEPTH-1:0]  s_valid;
  logic [DEPTH-1:0]  s_wen;
  logic [ADDR_W-1:0] s_dst  [DEPTH];
  logic [DATA_W-1:0] s_data [DEPTH];
  logic [ADDR_W-1:0] query  [NUM_SRC];

  // A stall in any later stage also freezes every earlier stage.
  always_comb begin
    hold = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hold[k] = |(stall >> k);
    end
  end

  assign in_ready = !hold[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      pipe_stage_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush[0]),
        .hold       (hold[0]),
        .bubble     (1'b0),
        .prev_valid (in_valid),
        .prev_wen   (in_valid & in_wen),
        .prev_dst   (in_dst),
        .prev_data  (in_data),
        .valid      (s_valid[0]),
        .wen        (s_wen[0]),
        .dst        (s_dst[0]),
        .data       (s_data[0])
      );
    end else begin : g_body
      pipe_stage_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush[k]),
        .hold       (hold[k]),
        .bubble     (hold[k-1]),
        .prev_valid (s_valid[k-1]),
        .prev_wen   (s_wen[k-1]),
        .prev_dst   (s_dst[k-1]),
        .prev_data  (s_data[k-1]),
        .valid      (s_valid[k]),
        .wen        (s_wen[k]),
        .dst        (s_dst[k]),
        .data       (s_data[k])
      );
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_query
    assign query[i] = src_addr[i*ADDR_W +: ADDR_W];
  end

  // Scan oldest to youngest so the youngest matching stage is the one left standing.
  always_comb begin
    fwd_hit   = '0;
    fwd_stage = '0;
    fwd_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (query[i] != '0) begin
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (s_valid[k] && s_wen[k] && (s_dst[k] == query[i])) begin
            fwd_hit[i]                               = 1'b1;
            fwd_stage[i*STAGE_IDX_W +: STAGE_IDX_W] = STAGE_IDX_W'(k);
            fwd_data[i*DATA_W +: DATA_W]             = s_data[k];
          end
        end
      end
    end
  end

  assign out_valid   = s_valid[DEPTH-1];
  assign out_wen     = s_wen[DEPTH-1];
  assign out_dst     = s_dst[DEPTH-1];
  assign out_data    = s_data[DEPTH-1];
  assign stage_valid = s_valid;

endmodule

`default_nettype wire

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain: directed scenarios plus randomized traffic against a stage-array model.
`default_nettype none

module tb_pipe_chain;

  localparam int DEPTH   = 4;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int NUM_SRC = 2;

  logic                      clk;
  logic                      rst;
  logic                      in_valid;
  logic [DATA_W-1:0]         in_data;
  logic [ADDR_W-1:0]         in_dst;
  logic                      in_wen;
  logic                      in_ready;
  logic [DEPTH-1:0]          stall;
  logic [DEPTH-1:0]          flush;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic [NUM_SRC-1:0]        fwd_hit;
  logic [NUM_SRC*3-1:0]      fwd_stage;
  logic [NUM_SRC*DATA_W-1:0] fwd_data;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [ADDR_W-1:0]         out_dst;
  logic                      out_wen;
  logic [DEPTH-1:0]          stage_valid;

  int total  = 0;
  int passed = 0;

  // Reference model: what each stage holds, updated from the pipeline rules each clock.
  bit                m_valid [DEPTH];
  bit                m_wen   [DEPTH];
  logic [ADDR_W-1:0] m_dst   [DEPTH];
  logic [DATA_W-1:0] m_data  [DEPTH];

  pipe_chain #(
    .DEPTH   (DEPTH),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_SRC (NUM_SRC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_dst      (in_dst),
    .in_wen      (in_wen),
    .in_ready    (in_ready),
    .stall       (stall),
    .flush       (flush),
    .src_addr    (src_addr),
    .fwd_hit     (fwd_hit),
    .fwd_stage   (fwd_stage),
    .fwd_data    (fwd_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_dst     (out_dst),
    .out_wen     (out_wen),
    .stage_valid (stage_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    bit                nv [DEPTH];
    bit                nw [DEPTH];
    logic [ADDR_W-1:0] nd [DEPTH];
    logic [DATA_W-1:0] nx [DEPTH];
    bit                frozen [DEPTH];
    for (int k = 0; k < DEPTH; k++) begin
      frozen[k] = 1'b0;
      for (int j = k; j < DEPTH; j++) if (stall[j]) frozen[k] = 1'b1;
    end
    for (int k = 0; k < DEPTH; k++) begin
      nv[k] = m_valid[k]; nw[k] = m_wen[k]; nd[k] = m_dst[k]; nx[k] = m_data[k];
      if (flush[k]) begin
        nv[k] = 0; nw[k] = 0;
      end else if (frozen[k]) begin
        // contents stay
      end else if (k > 0 && frozen[k-1]) begin
        nv[k] = 0; nw[k] = 0;
      end else if (k == 0) begin
        nv[0] = in_valid; nw[0] = in_valid && in_wen; nd[0] = in_dst; nx[0] = in_data;
      end else begin
        nv[k] = m_valid[k-1]; nw[k] = m_wen[k-1]; nd[k] = m_dst[k-1]; nx[k] = m_data[k-1];
      end
    end
    @(posedge clk);
    for (int k = 0; k < DEPTH; k++) begin
      if (rst) begin
        m_valid[k] = 0; m_wen[k] = 0; m_dst[k] = '0; m_data[k] = '0;
      end else begin
        m_valid[k] = nv[k]; m_wen[k] = nw[k]; m_dst[k] = nd[k]; m_data[k] = nx[k];
      end
    end
    #1;
  endtask

  function automatic void exp_fwd(input logic [ADDR_W-1:0] a, output bit hit,
                                  output logic [2:0] stg, output logic [DATA_W-1:0] d);
    hit = 0; stg = '0; d = '0;
    if (a != '0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!hit && m_valid[k] && m_wen[k] && m_dst[k] == a) begin
          hit = 1; stg = 3'(k); d = m_data[k];
        end
      end
    end
  endfunction

  task automatic idle();
    in_valid = 0; in_wen = 0; in_dst = '0; in_data = '0; stall = '0; flush = '0;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a, input logic w);
    in_valid = 1; in_data = d; in_dst = a; in_wen = w;
  endtask

  task automatic test_reset();
    idle();
    src_addr = {5'd2, 5'd1};
    rst = 1; stall = 4'b0100; push(32'h99, 5'd1, 1);
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_ready_stall: got %b want 0", in_ready); else passed++;
    tick();
    stall = '0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_ready_free: got %b want 1", in_ready); else passed++;
    tick();
    rst = 0; idle();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (stage_valid !== 4'b0000) $display("FAIL reset_stage_valid: got %b want 0000", stage_valid); else passed++;
    total++; if (fwd_hit !== 2'b00) $display("FAIL reset_fwd_hit: got %b want 00", fwd_hit); else passed++;
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] expv [3];
    expv[0] = 32'h11; expv[1] = 32'h22; expv[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      push(expv[i], 5'd1, 1);
      tick();
    end
    idle();
    total++; if (out_valid !== 1'b0) $display("FAIL stream_early: out_valid %b want 0", out_valid); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== expv[i])
        $display("FAIL stream_out%0d: valid %b data %h want 1 %h", i, out_valid, out_data, expv[i]);
      else passed++;
    end
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL stream_drain: out_valid %b want 0", out_valid); else passed++;
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] seen [$];
    push(32'h41, 5'd1, 1); tick();
    push(32'h42, 5'd1, 1); tick();
    push(32'h43, 5'd1, 1); stall = 4'b0010;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL stall_ready: got %b want 0", in_ready); else passed++;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (stage_valid !== 4'b0011) $display("FAIL stall_frozen%0d: stage_valid %b want 0011", c, stage_valid);
      else passed++;
    end
    stall = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) seen.push_back(out_data);
      if (c == 0) push(32'h44, 5'd1, 1); else idle();
    end
    total++;
    if (seen.size() != 4) $display("FAIL stall_count: got %0d outputs want 4", seen.size());
    else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (seen[i] !== 32'h41 + i) $display("FAIL stall_order%0d: got %h want %h", i, seen[i], 32'h41 + i);
        else passed++;
      end
    end
  endtask

  task automatic test_flush_stall();
    push(32'h51, 5'd7, 1); tick();
    push(32'h52, 5'd9, 1); tick();
    push(32'h53, 5'd7, 1); stall = 4'b0010; flush = 4'b0010;
    src_addr = {5'd9, 5'd7};
    tick();
    idle();
    total++; if (stage_valid[1:0] !== 2'b01) $display("FAIL flush_stall_valid: got %b want 01", stage_valid[1:0]); else passed++;
    total++;
    if (fwd_hit[0] !== 1'b0 || fwd_data[31:0] !== 32'h0)
      $display("FAIL flush_killed_fwd: hit %b data %h want 0 0", fwd_hit[0], fwd_data[31:0]);
    else passed++;
    total++;
    if (fwd_hit[1] !== 1'b1 || fwd_stage[5:3] !== 3'd0 || fwd_data[63:32] !== 32'h52)
      $display("FAIL flush_retained: hit %b stage %0d data %h want 1 0 52", fwd_hit[1], fwd_stage[5:3], fwd_data[63:32]);
    else passed++;
    for (int c = 0; c < DEPTH + 1; c++) tick();
  endtask

  task automatic test_forwarding();
    push(32'hBB, 5'd3, 1); tick();
    push(32'hCC, 5'd5, 1); tick();
    push(32'hAA, 5'd3, 1); tick();
    idle();
    src_addr = {5'd5, 5'd3};
    #1;
    total++;
    if (fwd_hit[0] !== 1'b1 || fwd_stage[2:0] !== 3'd0 || fwd_data[31:0] !== 32'hAA)
      $display("FAIL fwd_youngest: hit %b stage %0d data %h want 1 0 aa", fwd_hit[0], fwd_stage[2:0], fwd_data[31:0]);
    else passed++;
    total++;
    if (fwd_hit[1] !== 1'b1 || fwd_stage[5:3] !== 3'd1 || fwd_data[63:32] !== 32'hCC)
      $display("FAIL fwd_stage1: hit %b stage %0d data %h want 1 1 cc", fwd_hit[1], fwd_stage[5:3], fwd_data[63:32]);
    else passed++;
    push(32'hDD, 5'd0, 1); tick();
    push(32'hEE, 5'd6, 0); tick();
    idle();
    src_addr = {5'd6, 5'd0};
    #1;
    total++;
    if (fwd_hit !== 2'b00 || fwd_stage !== 6'd0 || fwd_data !== '0)
      $display("FAIL fwd_exclude: hit %b stage %h data %h want 0 0 0", fwd_hit, fwd_stage, fwd_data);
    else passed++;
    for (int c = 0; c < DEPTH + 1; c++) tick();
  endtask

  task automatic test_midstream_reset();
    push(32'h61, 5'd1, 1); tick();
    push(32'h62, 5'd1, 1); tick();
    push(32'h63, 5'd1, 1); tick();
    total++; if (stage_valid !== 4'b0111) $display("FAIL mid_fill: stage_valid %b want 0111", stage_valid); else passed++;
    push(32'h64, 5'd1, 1); stall = 4'b0001; flush = 4'b0010; rst = 1;
    tick();
    rst = 0; stall = '0; flush = '0;
    total++; if (stage_valid !== 4'b0000) $display("FAIL mid_reset_clear: stage_valid %b want 0000", stage_valid); else passed++;
    push(32'h71, 5'd1, 1); tick();
    push(32'h72, 5'd1, 1); tick();
    idle();
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL mid_early: out_valid %b want 0", out_valid); else passed++;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h71)
      $display("FAIL mid_fresh: valid %b data %h want 1 71", out_valid, out_data);
    else passed++;
    for (int c = 0; c < DEPTH; c++) tick();
  endtask

  task automatic test_random();
    bit                hit;
    logic [2:0]        stg;
    logic [DATA_W-1:0] d;
    logic [DEPTH-1:0]  exp_sv;
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(3) != 0);
      in_data  = $urandom;
      in_dst   = ADDR_W'($urandom_range(3));
      in_wen   = $urandom_range(1);
      rst      = ($urandom_range(99) == 0);
      for (int k = 0; k < DEPTH; k++) begin
        stall[k] = ($urandom_range(7) == 0);
        flush[k] = ($urandom_range(15) == 0);
      end
      for (int i = 0; i < NUM_SRC; i++) src_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(3));
      #1;
      total++;
      if (in_ready !== (stall == '0)) $display("FAIL rnd_ready@%0d: got %b stall %b", n, in_ready, stall);
      else passed++;
      tick();
      for (int k = 0; k < DEPTH; k++) exp_sv[k] = m_valid[k];
      total++;
      if (stage_valid !== exp_sv) $display("FAIL rnd_stage_valid@%0d: got %b want %b", n, stage_valid, exp_sv);
      else passed++;
      total++;
      if (out_wen !== m_wen[DEPTH-1]) $display("FAIL rnd_out_wen@%0d: got %b want %b", n, out_wen, m_wen[DEPTH-1]);
      else passed++;
      if (m_valid[DEPTH-1]) begin
        total++;
        if (out_data !== m_data[DEPTH-1] || out_dst !== m_dst[DEPTH-1])
          $display("FAIL rnd_out@%0d: got %h/%0d want %h/%0d", n, out_data, out_dst, m_data[DEPTH-1], m_dst[DEPTH-1]);
        else passed++;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        exp_fwd(src_addr[i*ADDR_W +: ADDR_W], hit, stg, d);
        total++;
        if (fwd_hit[i] !== hit || fwd_stage[i*3 +: 3] !== stg || fwd_data[i*DATA_W +: DATA_W] !== d)
          $display("FAIL rnd_fwd%0d@%0d: got %b/%0d/%h want %b/%0d/%h", i, n,
                   fwd_hit[i], fwd_stage[i*3 +: 3], fwd_data[i*DATA_W +: DATA_W], hit, stg, d);
        else passed++;
      end
    end
    rst = 0; idle();
  endtask

  initial begin
    rst = 1;
    idle();
    src_addr = '0;
    test_reset();
    test_stream();
    test_stall();
    test_flush_stall();
    test_forwarding();
    test_midstream_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
